// File: rtl/sdram_bus_bridge_pkg.sv
// rtl/sdram_bus_bridge_pkg.sv - shared encodings and request-decode helpers for the SDRAM bus bridge
package sdram_bus_bridge_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [1:0] WLEN_RD32 = 2'b00;
    localparam logic [1:0] WLEN_WR8  = 2'b01;
    localparam logic [1:0] WLEN_WR16 = 2'b10;
    localparam logic [1:0] WLEN_WR32 = 2'b11;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam int CNT_W = 16;

    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [1:0] wlen_code(input logic we, input logic [1:0] size);
        logic [1:0] code;
        if (!we) begin
            code = WLEN_RD32;
        end else begin
            case (size)
                SIZE_BYTE: code = WLEN_WR8;
                SIZE_HALF: code = WLEN_WR16;
                default:   code = WLEN_WR32;
            endcase
        end
        return code;
    endfunction

    // Loads always fetch the whole word; only sub-word stores need the exact byte address.
    function automatic logic [25:0] mem_addr(input logic we, input logic [1:0] size,
                                             input logic [25:0] addr);
        logic [25:0] a;
        if (we && (size != SIZE_WORD)) a = addr;
        else                           a = {addr[25:2], 2'b00};
        return a;
    endfunction

endpackage

// File: rtl/sdram_load_align.sv
// rtl/sdram_load_align.sv - selects the addressed lane of a read word and sign/zero-extends it
module sdram_load_align
    import sdram_bus_bridge_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        zext,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{addr, 3'b000} +: 8];
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: data = zext ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SIZE_HALF: data = zext ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/sdram_bus_bridge.sv
// rtl/sdram_bus_bridge.sv - single-outstanding CPU data port to SDRAM controller bridge
module sdram_bus_bridge
    import sdram_bus_bridge_pkg::*;
#(
    parameter int INIT_WAIT      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [25:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_WLEN,
    output logic        mem_EN_N,
    input  logic        mem_READY,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] INIT_LAST    = CNT_W'(INIT_WAIT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lat_we;
    logic             lat_zext;
    logic [1:0]       lat_size;
    logic [1:0]       lat_lane;
    logic             timed_out;
    logic [31:0]      load_data;
    logic             unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:26];

    sdram_load_align u_load_align (
        .rdata (mem_rdata),
        .addr  (lat_lane),
        .size  (lat_size),
        .zext  (lat_zext),
        .data  (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            cnt         <= '0;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            mem_EN_N    <= 1'b1;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_WLEN    <= WLEN_RD32;
            lat_we      <= 1'b0;
            lat_zext    <= 1'b0;
            lat_size    <= SIZE_BYTE;
            lat_lane    <= 2'b00;
            timed_out   <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (cnt == INIT_LAST) begin
                        cnt       <= '0;
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        lat_we    <= req_we;
                        lat_zext  <= req_unsigned;
                        lat_size  <= req_size;
                        lat_lane  <= req_addr[1:0];
                        timed_out <= 1'b0;
                        cnt       <= '0;
                        if (req_bad(req_size, req_addr[1:0])) begin
                            state <= ST_RESP;
                        end else begin
                            mem_address <= mem_addr(req_we, req_size, req_addr[25:0]);
                            mem_wdata   <= req_wdata;
                            mem_WLEN    <= wlen_code(req_we, req_size);
                            mem_EN_N    <= 1'b0;
                            state       <= ST_ISSUE;
                        end
                    end
                end

                // READY falling is the controller's acknowledgement; EN_N must rise at once.
                ST_ISSUE: begin
                    if (!mem_READY) begin
                        mem_EN_N <= 1'b1;
                        cnt      <= cnt + 1'b1;
                        state    <= ST_WAIT;
                    end else if (cnt >= TIMEOUT_LAST) begin
                        mem_EN_N   <= 1'b1;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        timed_out  <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (mem_READY) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= lat_we ? 32'h0 : load_data;
                        state      <= ST_RESP;
                    end else if (cnt >= TIMEOUT_LAST) begin
                        mem_EN_N   <= 1'b1;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        timed_out  <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Rejected requests arrive here without a pulse and get it one cycle later.
                ST_RESP: begin
                    if (resp_valid) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        cnt        <= '0;
                        if (timed_out) begin
                            state <= ST_INIT;
                        end else begin
                            state     <= ST_IDLE;
                            req_ready <= 1'b1;
                        end
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_bus_bridge.sv
// tb/tb_sdram_bus_bridge.sv - scoreboard bench for sdram_bus_bridge with a negedge controller model
module tb_sdram_bus_bridge;

    localparam int INIT_WAIT = 8;
    localparam int TIMEOUT   = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [25:0] mem_address;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_WLEN;
    logic        mem_EN_N;
    logic        mem_READY = 1'b1;
    logic [31:0] mem_rdata = 32'h0;

    sdram_bus_bridge #(.INIT_WAIT(INIT_WAIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_WLEN(mem_WLEN),
        .mem_EN_N(mem_EN_N), .mem_READY(mem_READY), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [25:0] addr;
        logic [1:0]  wlen;
        logic [31:0] wdata;
    } cmd_t;

    exp_t exp_q[$];
    cmd_t cmd_q[$];
    logic [7:0] cmem [int];
    logic [7:0] rmem [int];

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int resp_seen = 0;
    logic ctl_hang = 1'b0;
    logic ctl_stuck = 1'b0;
    logic ctl_chk_en = 1'b0;
    int ctl_left = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] cbyte(input int a);
        return cmem.exists(a) ? cmem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rbyte(input int a);
        return rmem.exists(a) ? rmem[a] : 8'h00;
    endfunction

    // Controller model: no reset, acts on negedge, latency counted from the accepting negedge.
    always @(negedge clk) begin
        int a;
        cmd_t c;
        if (ctl_chk_en) begin
            ctl_chk_en = 1'b0;
            chk("en_one_cycle", {31'b0, mem_EN_N}, 32'd1);
        end
        if (!mem_READY) begin
            if (ctl_hang) begin
                ctl_stuck = 1'b1;
            end else if (ctl_stuck) begin
                ctl_stuck = 1'b0;
                mem_READY = 1'b1;
            end else begin
                ctl_left--;
                if (ctl_left == 0) begin
                    a = int'(mem_address);
                    case (mem_WLEN)
                        2'b00: mem_rdata = {cbyte(a + 3), cbyte(a + 2), cbyte(a + 1), cbyte(a)};
                        2'b01: cmem[a] = mem_wdata[7:0];
                        2'b10: for (int i = 0; i < 2; i++) cmem[a + i] = mem_wdata[8*i +: 8];
                        default: for (int i = 0; i < 4; i++) cmem[a + i] = mem_wdata[8*i +: 8];
                    endcase
                    mem_READY = 1'b1;
                end
            end
        end else if (!mem_EN_N) begin
            if (cmd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_en addr=%h wlen=%b required=no_transaction", mem_address, mem_WLEN);
            end else begin
                c = cmd_q.pop_front();
                chk("mem_address", {6'b0, mem_address}, {6'b0, c.addr});
                chk("mem_WLEN", {30'b0, mem_WLEN}, {30'b0, c.wlen});
                chk("mem_wdata", mem_wdata, c.wdata);
            end
            mem_READY = 1'b0;
            ctl_left = (mem_WLEN == 2'b00) ? 4 : ((mem_WLEN == 2'b11) ? 3 : 2);
            ctl_chk_en = 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid) begin
            resp_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp rdata=%h err=%b required=no_response", resp_rdata, resp_err);
            end else begin
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                chk("resp_latency", 32'(edge_n - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic check_reset_outs(input string tag);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
        chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
        chk({tag, "_mem_EN_N"}, {31'b0, mem_EN_N}, 32'd1);
        chk({tag, "_mem_address"}, {6'b0, mem_address}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_WLEN"}, {30'b0, mem_WLEN}, 32'd0);
    endtask

    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic hang);
        int guard;
        int a;
        int n;
        logic [31:0] v;
        exp_t e;
        cmd_t c;
        guard = 0;
        @(negedge clk); #1;
        while (!req_ready && guard < 300) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we = we;
        req_size = size;
        req_unsigned = uns;
        req_addr = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        e.acc = edge_n;
        e.rdata = 32'h0;
        e.err = 1'b0;
        a = int'(addr[25:0]);
        n = 1 << size;
        if (size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)) begin
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            c.addr = (we && size != 2'd2) ? addr[25:0] : {addr[25:2], 2'b00};
            c.wlen = we ? size + 2'd1 : 2'd0;
            c.wdata = wdata;
            cmd_q.push_back(c);
            if (hang) begin
                e.err = 1'b1;
                e.lat = TIMEOUT;
            end else if (we) begin
                for (int i = 0; i < n; i++) rmem[a + i] = wdata[8*i +: 8];
                e.lat = (size == 2'd2) ? 4 : 3;
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | ({24'h0, rbyte(a + i)} << (8 * i));
                if (!uns && size == 2'd0) v = {{24{v[7]}}, v[7:0]};
                if (!uns && size == 2'd1) v = {{16{v[15]}}, v[15:0]};
                e.rdata = v;
                e.lat = 5;
            end
        end
        exp_q.push_back(e);
        // Held-high garbage while busy: the bridge must ignore it.
        req_we = 1'($urandom);
        req_size = 2'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic wait_resp(input int start);
        int guard;
        guard = 0;
        while (resp_seen == start && guard < 300) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("resp_arrived", {31'b0, resp_seen != start}, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int s;
        s = resp_seen;
        send(we, size, uns, addr, wdata, 1'b0);
        wait_resp(s);
    endtask

    task automatic wait_ready(input int ref_edge, input string name);
        int guard;
        guard = 0;
        while (!req_ready && guard < 300) begin
            @(negedge clk); #1;
            guard++;
        end
        chk(name, 32'(edge_n - ref_edge), 32'(INIT_WAIT));
    endtask

    initial begin
        int s;
        int ref_edge;
        logic [31:0] r;
        logic [1:0] sz;
        for (int i = 0; i < 4; i++) begin
            cmem[32'h100 + i] = 8'(32'h80FF1234 >> (8 * i));
            rmem[32'h100 + i] = 8'(32'h80FF1234 >> (8 * i));
            cmem[32'h104 + i] = 8'(32'hDEADBEEF >> (8 * i));
            rmem[32'h104 + i] = 8'(32'hDEADBEEF >> (8 * i));
        end
        repeat (3) @(negedge clk);
        check_reset_outs("por");
        rst = 1'b0;
        ref_edge = edge_n;
        wait_ready(ref_edge, "init_after_reset");

        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h0000_0201, 32'h1234_56A5);
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_0203, 32'hCAFE_F00D);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0);
        do_req(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'hFC00_0104, 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_0201, 32'h0);

        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 9);
            sz = (r == 9) ? 2'd3 : 2'(r % 3);
            do_req(1'($urandom), sz, 1'($urandom),
                   {6'($urandom), 26'(32'h100 + $urandom_range(0, 31))}, $urandom);
        end

        ctl_hang = 1'b1;
        s = resp_seen;
        send(1'b0, 2'd2, 1'b0, 32'h0000_0108, 32'h0, 1'b1);
        wait_resp(s);
        ctl_hang = 1'b0;
        ref_edge = edge_n + 1;
        wait_ready(ref_edge, "init_after_timeout");
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0);

        s = resp_seen;
        send(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outs("mid_wait");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        ref_edge = edge_n;
        wait_ready(ref_edge, "init_after_mid_reset");
        do_req(1'b0, 2'd1, 1'b1, 32'h0000_0106, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_0110, 32'h1357_9BDF);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0110, 32'h0);

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size() + cmd_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
